// File: rtl/lcd_fb_pkg.sv
// Shared types and constants for the LCD framebuffer streaming engine.
// Holds the request FSM encodings, memory burst-length width and byte order.
package lcd_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDATA = 2'd2,
        ST_FLUSH = 2'd3
    } req_state_t;

    localparam int MI_LEN_W = 7;

    // Framebuffer words are sent to the panel most significant byte first.
    localparam bit BYTE_MSB_FIRST = 1'b1;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [1:0] sel;
        sel = BYTE_MSB_FIRST ? (2'd3 - idx) : idx;
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_fb_fifo.sv
// 32-bit synchronous FIFO, 2^FIFO_AW deep, with a free-space count.
// The head entry is always visible on rdata so a pop can feed a register in the same cycle.
module lcd_fb_fifo #(
    parameter int FIFO_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [31:0]      wdata,
    input  logic             pop,
    output logic [31:0]      rdata,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] free
);
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] ONE   = (FIFO_AW+1)'(1);

    logic [31:0]      mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] count;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign free  = DEPTH - count;
    assign rdata = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + ONE;
        end
    end

endmodule

// File: rtl/lcd_fb_stream.sv
// Streams a framebuffer from PSRAM to the LCD PHY: burst reads into a FIFO,
// then unpacks each 32-bit word into four RS=1 data bytes.
module lcd_fb_stream
    import lcd_fb_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int CNT_WIDTH  = 17,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [CNT_WIDTH-1:0]  cfg_words,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done_stb,
    output logic [ADDR_WIDTH-1:0] mi_addr,
    output logic [MI_LEN_W-1:0]   mi_len,
    output logic                  mi_rw,
    output logic                  mi_valid,
    input  logic                  mi_ready,
    input  logic [31:0]           mi_rdata,
    input  logic                  mi_rstb,
    input  logic                  mi_rlast,
    output logic [7:0]            phy_data,
    output logic                  phy_rs,
    output logic                  phy_valid,
    input  logic                  phy_ready
);
    localparam logic [FIFO_AW:0]    BURST_FREE   = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] BURST_WORDS = CNT_WIDTH'(BURST_LEN);
    localparam logic [MI_LEN_W-1:0] BURST_LEN_M1 = MI_LEN_W'(BURST_LEN - 1);

    req_state_t           state;
    logic [CNT_WIDTH-1:0] words_left;
    logic                 aborting;
    logic [31:0]          word_q;
    logic [1:0]           byte_idx;
    logic                 out_load;
    logic                 drained;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_clr;
    logic [31:0]          fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_free;

    function automatic logic [MI_LEN_W-1:0] burst_len_m1(input logic [CNT_WIDTH-1:0] words);
        return (words >= BURST_WORDS) ? BURST_LEN_M1 : MI_LEN_W'(words - CNT_WIDTH'(1));
    endfunction

    assign mi_rw     = 1'b1;
    assign phy_rs    = 1'b1;
    assign out_load  = !phy_valid || phy_ready;
    assign fifo_push = mi_rstb && (state == ST_RDATA);
    assign fifo_clr  = (state == ST_FLUSH);
    assign fifo_pop  = (state != ST_FLUSH) && out_load && (byte_idx == 2'd0) && !fifo_empty;
    // Everything fetched has left the engine, including the byte on the PHY this cycle.
    assign drained   = (words_left == '0) && fifo_empty && (byte_idx == 2'd0) && out_load;

    lcd_fb_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .wdata (mi_rdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done_stb   <= 1'b0;
            mi_valid   <= 1'b0;
            mi_addr    <= '0;
            mi_len     <= '0;
            words_left <= '0;
            aborting   <= 1'b0;
        end else begin
            done_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!busy) begin
                        if (start) begin
                            mi_addr    <= cfg_base;
                            words_left <= cfg_words;
                            if (cfg_words == '0) begin
                                done_stb <= 1'b1;
                            end else begin
                                busy     <= 1'b1;
                                mi_valid <= 1'b1;
                                mi_len   <= burst_len_m1(cfg_words);
                                state    <= ST_REQ;
                            end
                        end
                    end else if (abort) begin
                        state <= ST_FLUSH;
                    end else if ((words_left != '0) && (fifo_free >= BURST_FREE)) begin
                        mi_valid <= 1'b1;
                        mi_len   <= burst_len_m1(words_left);
                        state    <= ST_REQ;
                    end else if (drained) begin
                        done_stb <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mi_ready) begin
                        mi_valid   <= 1'b0;
                        mi_addr    <= mi_addr + ADDR_WIDTH'(mi_len) + ADDR_WIDTH'(1);
                        words_left <= words_left - (CNT_WIDTH'(mi_len) + CNT_WIDTH'(1));
                        aborting   <= abort;
                        state      <= ST_RDATA;
                    end else if (abort) begin
                        mi_valid <= 1'b0;
                        state    <= ST_FLUSH;
                    end
                end
                ST_RDATA: begin
                    // The read channel cannot be stalled, so an abort waits for the burst to end.
                    if (abort)
                        aborting <= 1'b1;
                    if (mi_rstb && mi_rlast)
                        state <= (aborting || abort) ? ST_FLUSH : ST_IDLE;
                end
                ST_FLUSH: begin
                    words_left <= '0;
                    if (out_load) begin
                        busy     <= 1'b0;
                        aborting <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_valid <= 1'b0;
            phy_data  <= '0;
            byte_idx  <= 2'd0;
        end else if (state == ST_FLUSH) begin
            byte_idx <= 2'd0;
            if (out_load)
                phy_valid <= 1'b0;
        end else if (out_load) begin
            if (byte_idx != 2'd0) begin
                phy_data  <= word_byte(word_q, byte_idx);
                phy_valid <= 1'b1;
                byte_idx  <= byte_idx + 2'd1;
            end else if (!fifo_empty) begin
                phy_data  <= word_byte(fifo_rdata, 2'd0);
                phy_valid <= 1'b1;
                byte_idx  <= 2'd1;
            end else begin
                phy_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop)
            word_q <= fifo_rdata;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_lcd_fb_stream.sv
// Self-checking bench for lcd_fb_stream: memory and PHY models with a byte scoreboard
// and an expected-request queue.
module tb_lcd_fb_stream;
    localparam int AW = 22;
    localparam int CW = 17;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [6:0]    len;
    } req_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] cfg_base;
    logic [CW-1:0] cfg_words;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done_stb;
    logic [AW-1:0] mi_addr;
    logic [6:0]    mi_len;
    logic          mi_rw;
    logic          mi_valid;
    logic          mi_ready;
    logic [31:0]   mi_rdata;
    logic          mi_rstb;
    logic          mi_rlast;
    logic [7:0]    phy_data;
    logic          phy_rs;
    logic          phy_valid;
    logic          phy_ready;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_bytes = 0;
    int   n_beats = 0;
    int   n_done = 0;
    int   n_valid = 0;
    int   first_beat_cyc = -1;
    int   first_valid_cyc = -1;
    int   last_acc_cyc = -1;
    int   ready_pct = 100;
    int   gap_pct = 0;
    int   abort_at_beat = 0;
    logic [7:0] exp_q[$];
    req_t       req_q[$];

    lcd_fb_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_base  (cfg_base),
        .cfg_words (cfg_words),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done_stb  (done_stb),
        .mi_addr   (mi_addr),
        .mi_len    (mi_len),
        .mi_rw     (mi_rw),
        .mi_valid  (mi_valid),
        .mi_ready  (mi_ready),
        .mi_rdata  (mi_rdata),
        .mi_rstb   (mi_rstb),
        .mi_rlast  (mi_rlast),
        .phy_data  (phy_data),
        .phy_rs    (phy_rs),
        .phy_valid (phy_valid),
        .phy_ready (phy_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return 32'h11223344 + 32'h44444444 * (32'(a) - 32'h100);
    endfunction

    // PSRAM model: accepts requests, checks them, returns beats and records expected bytes.
    initial begin : mem_model
        int            beats_left;
        int            beat_idx;
        logic [AW-1:0] beat_addr;
        req_t          r;
        beats_left = 0;
        beat_idx = 0;
        beat_addr = '0;
        mi_ready = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0; mi_rdata = '0; abort = 1'b0;
        forever begin
            @(negedge clk);
            mi_ready = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0; abort = 1'b0;
            if (!rst_n) begin
                beats_left = 0;
            end else begin
                if (mi_valid === 1'b1) n_valid++;
                if (beats_left > 0) begin
                    if (int'($urandom_range(0, 99)) >= gap_pct) begin
                        mi_rdata = word_of(beat_addr);
                        for (int b = 0; b < 4; b++) exp_q.push_back(8'(mi_rdata >> (24 - 8 * b)));
                        mi_rstb = 1'b1;
                        mi_rlast = (beats_left == 1);
                        beat_idx++;
                        n_beats++;
                        if (first_beat_cyc < 0) first_beat_cyc = cyc;
                        if (beat_idx == abort_at_beat) begin
                            abort = 1'b1;
                            abort_at_beat = 0;
                        end
                        beat_addr++;
                        beats_left--;
                    end
                end else if (mi_valid === 1'b1 && int'($urandom_range(0, 99)) >= gap_pct) begin
                    mi_ready = 1'b1;
                    checks++;
                    if (req_q.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected: got addr=%h len=%0d, expected no request", mi_addr, mi_len);
                    end else begin
                        r = req_q.pop_front();
                        if (mi_addr !== r.addr || mi_len !== r.len) begin
                            errors++;
                            $display("FAIL req_fields: got addr=%h len=%0d, expected addr=%h len=%0d",
                                     mi_addr, mi_len, r.addr, r.len);
                        end
                    end
                    checks++;
                    if (exp_q.size() > 68) begin
                        errors++;
                        $display("FAIL req_fifo_space: got %0d bytes outstanding, expected <= 68", exp_q.size());
                    end
                    beats_left = int'(mi_len) + 1;
                    beat_addr = mi_addr;
                    beat_idx = 0;
                end
            end
        end
    end

    // PHY model: random ready, scoreboard compare on every accepted byte, hold check when stalled.
    initial begin : phy_model
        bit         stalled;
        logic [7:0] held;
        logic [7:0] e;
        stalled = 1'b0;
        held = '0;
        phy_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (phy_valid !== 1'b1 || phy_data !== held) begin
                        errors++;
                        $display("FAIL phy_hold: got valid=%b data=%h, expected valid=1 data=%h", phy_valid, phy_data, held);
                    end
                end
                phy_ready = (int'($urandom_range(0, 99)) < ready_pct);
                if (phy_valid === 1'b1) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (phy_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL phy_extra: got byte %h, expected none", phy_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (phy_data !== e) begin
                                errors++;
                                $display("FAIL phy_byte: got %h, expected %h", phy_data, e);
                            end
                        end
                        n_bytes++;
                        last_acc_cyc = cyc;
                    end
                end
                stalled = (phy_valid === 1'b1) && !phy_ready;
                held = phy_data;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && done_stb === 1'b1) n_done++;
    end

    task automatic kick(input logic [AW-1:0] base, input logic [CW-1:0] words);
        @(negedge clk);
        cfg_base = base;
        cfg_words = words;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_stb === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done_stb, mi_valid, phy_valid} !== 4'b0000 || mi_addr !== '0 || mi_len !== '0 || phy_data !== '0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b mi_valid=%b phy_valid=%b addr=%h len=%0d data=%h, expected all 0",
                     busy, done_stb, mi_valid, phy_valid, mi_addr, mi_len, phy_data);
        end
        checks++;
        if (mi_rw !== 1'b1 || phy_rs !== 1'b1) begin
            errors++;
            $display("FAIL tie_offs: got mi_rw=%b phy_rs=%b, expected 1 1", mi_rw, phy_rs);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_transfer(input string name, input logic [AW-1:0] base, input logic [CW-1:0] words,
                                input int exp_bytes, input int budget);
        int b0;
        bit ok;
        b0 = n_bytes;
        kick(base, words);
        wait_done(budget, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done: got no done_stb within %0d cycles, expected one", name, budget);
        end else begin
            checks++;
            if (busy !== 1'b0 || cyc != last_acc_cyc + 1) begin
                errors++;
                $display("FAIL %s_done_timing: got busy=%b at cycle %0d, expected busy=0 at cycle %0d",
                         name, busy, cyc, last_acc_cyc + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (n_bytes - b0 != exp_bytes || exp_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL %s_totals: got bytes=%0d left=%0d reqs_left=%0d, expected bytes=%0d left=0 reqs_left=0",
                     name, n_bytes - b0, exp_q.size(), req_q.size(), exp_bytes);
        end
        checks++;
        if (done_stb !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got done_stb=%b one cycle later, expected 0", name, done_stb);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int b0;
        ready_pct = 100; gap_pct = 0;
        req_q.push_back('{22'h100, 7'd3});
        first_beat_cyc = -1; first_valid_cyc = -1;
        b0 = n_bytes;
        kick(22'h100, 17'd4);
        checks++;
        if (busy !== 1'b1 || mi_valid !== 1'b1 || mi_addr !== 22'h100 || mi_len !== 7'd3) begin
            errors++;
            $display("FAIL basic_start: got busy=%b mi_valid=%b addr=%h len=%0d, expected 1 1 100 3",
                     busy, mi_valid, mi_addr, mi_len);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || busy !== 1'b0 || cyc != last_acc_cyc + 1) begin
            errors++;
            $display("FAIL basic_done: got ok=%b busy=%b at cycle %0d, expected done with busy=0 at cycle %0d",
                     ok, busy, cyc, last_acc_cyc + 1);
        end
        checks++;
        if (first_valid_cyc != first_beat_cyc + 2) begin
            errors++;
            $display("FAIL basic_latency: got first byte at cycle %0d, expected %0d", first_valid_cyc, first_beat_cyc + 2);
        end
        @(negedge clk);
        checks++;
        if (n_bytes - b0 != 16 || exp_q.size() != 0 || req_q.size() != 0 || done_stb !== 1'b0) begin
            errors++;
            $display("FAIL basic_totals: got bytes=%0d left=%0d reqs_left=%0d done=%b, expected 16 0 0 0",
                     n_bytes - b0, exp_q.size(), req_q.size(), done_stb);
        end
    endtask

    task automatic test_multi_burst();
        ready_pct = 100; gap_pct = 30;
        req_q.push_back('{22'h100, 7'd15});
        req_q.push_back('{22'h110, 7'd15});
        req_q.push_back('{22'h120, 7'd4});
        run_transfer("multi", 22'h100, 17'd37, 148, 1000);
    endtask

    task automatic test_backpressure();
        bit ok;
        int b0;
        ready_pct = 25; gap_pct = 20;
        req_q.push_back('{22'h1000, 7'd15});
        req_q.push_back('{22'h1010, 7'd15});
        req_q.push_back('{22'h1020, 7'd7});
        b0 = n_bytes;
        kick(22'h1000, 17'd40);
        repeat (10) @(negedge clk);
        cfg_base = 22'h3000; cfg_words = 17'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4000, ok);
        checks++;
        if (!ok || busy !== 1'b0 || cyc != last_acc_cyc + 1) begin
            errors++;
            $display("FAIL bp_done: got ok=%b busy=%b at cycle %0d, expected done with busy=0 at cycle %0d",
                     ok, busy, cyc, last_acc_cyc + 1);
        end
        @(negedge clk);
        checks++;
        if (n_bytes - b0 != 160 || exp_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL bp_totals: got bytes=%0d left=%0d reqs_left=%0d, expected 160 0 0",
                     n_bytes - b0, exp_q.size(), req_q.size());
        end
        ready_pct = 100; gap_pct = 0;
    endtask

    task automatic test_zero_len();
        int v0;
        int d0;
        v0 = n_valid;
        d0 = n_done;
        kick(22'h55, 17'd0);
        checks++;
        if (done_stb !== 1'b1 || busy !== 1'b0 || mi_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b mi_valid=%b at cycle 1, expected 1 0 0", done_stb, busy, mi_valid);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_valid != v0 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL zero_quiet: got mi_valid cycles=%0d done pulses=%0d, expected 0 1", n_valid - v0, n_done - d0);
        end
    endtask

    task automatic test_wrap();
        ready_pct = 100; gap_pct = 10;
        req_q.push_back('{22'h3FFFF8, 7'd15});
        req_q.push_back('{22'h000008, 7'd15});
        run_transfer("wrap", 22'h3FFFF8, 17'd32, 128, 1000);
    endtask

    task automatic test_abort();
        int  nb0;
        int  nd0;
        bit  fell;
        ready_pct = 100; gap_pct = 0;
        req_q.push_back('{22'h200, 7'd15});
        nb0 = n_beats;
        nd0 = n_done;
        abort_at_beat = 5;
        kick(22'h200, 17'd40);
        fell = 1'b0;
        for (int i = 0; i < 300 && !fell; i++) begin
            @(negedge clk);
            if (busy === 1'b0) fell = 1'b1;
        end
        checks++;
        if (!fell || n_beats - nb0 != 16) begin
            errors++;
            $display("FAIL abort_flush: got busy_low=%b beats=%0d, expected 1 16", fell, n_beats - nb0);
        end
        checks++;
        if (phy_valid !== 1'b0 || mi_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got phy_valid=%b mi_valid=%b, expected 0 0", phy_valid, mi_valid);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (n_done != nd0 || req_q.size() != 0 || n_beats - nb0 != 16) begin
            errors++;
            $display("FAIL abort_quiet: got done pulses=%0d reqs_left=%0d beats=%0d, expected 0 0 16",
                     n_done - nd0, req_q.size(), n_beats - nb0);
        end
        exp_q.delete();
        abort_at_beat = 0;
        req_q.push_back('{22'h100, 7'd3});
        run_transfer("post_abort", 22'h100, 17'd4, 16, 200);
    endtask

    task automatic test_reset_mid();
        int  nb0;
        bit  reached;
        ready_pct = 50; gap_pct = 0;
        req_q.push_back('{22'h100, 7'd15});
        nb0 = n_beats;
        kick(22'h100, 17'd37);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            if (n_beats - nb0 >= 3) reached = 1'b1;
        end
        checks++;
        if (!reached || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: got beats=%0d busy=%b, expected >=3 1", n_beats - nb0, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done_stb, mi_valid, phy_valid} !== 4'b0000 || mi_addr !== '0 || mi_len !== '0 || phy_data !== '0) begin
            errors++;
            $display("FAIL rstmid_values: got busy=%b done=%b mi_valid=%b phy_valid=%b addr=%h len=%0d data=%h, expected all 0",
                     busy, done_stb, mi_valid, phy_valid, mi_addr, mi_len, phy_data);
        end
        repeat (3) @(negedge clk);
        exp_q.delete();
        req_q.delete();
        #2 rst_n = 1'b1;
        ready_pct = 100;
        req_q.push_back('{22'h100, 7'd3});
        run_transfer("post_reset", 22'h100, 17'd4, 16, 200);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_base = '0;
        cfg_words = '0;
        test_reset();
        test_basic();
        test_multi_burst();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
